seq_det_ctrl: RTL and testbench

Programmable serial sequence-detection controller. It arms a shift-register pattern matcher from a configuration snapshot and paces the incoming bit stream with a valid/ready handshake. It counts pattern matches and ends the run when a match target or a frame length is reached. It sits between the bit-stream source and status/interrupt logic, and replaces hard-coded per-pattern detector FSMs with one configurable block.

---
 rtl/seq_det_pkg.sv | 8 +
 rtl/seq_match_core.sv | 38 +++
 rtl/seq_det_ctrl.sv | 77 +++++++
 tb/tb_seq_det_ctrl.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// seq_det_pkg: state and status encodings shared by seq_det_ctrl and its testbench
package seq_det_pkg;
  typedef enum logic [1:0] {IDLE, ARM, RUN, DONE} state_t;
  localparam logic [1:0] ST_NONE   = 2'b00;
  localparam logic [1:0] ST_TARGET = 2'b01;
  localparam logic [1:0] ST_FRAME  = 2'b10;
  localparam logic [1:0] ST_CFGERR = 2'b11;
endpackage

// File: rtl/seq_match_core.sv
// seq_match_core: bit history, fill count and masked pattern compare; hit reflects the post-shift history (SEQ_DET_CTRL_OVERLAP_EN keeps fill after a match); ports clk, rst, clear, shift, b, len, pattern -> hit
module seq_match_core #(
  parameter int PAT_W = 8,
  parameter int LEN_W = $clog2(PAT_W + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             shift,
  input  logic             b,
  input  logic [LEN_W-1:0] len,
  input  logic [PAT_W-1:0] pattern,
  output logic             hit
);
  logic [PAT_W-1:0] hist, hist_n, mask;
  logic [LEN_W-1:0] fill, fill_n;
  always_comb begin
    hist_n = {hist[PAT_W-2:0], b};
    fill_n = fill >= len ? len : fill + LEN_W'(1);
    mask   = ~({PAT_W{1'b1}} << len);
    hit    = shift && fill_n >= len && ((hist_n ^ pattern) & mask) == '0;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      hist <= '0;
      fill <= '0;
    end else if (clear) begin
      hist <= '0;
      fill <= '0;
    end else if (shift) begin
      hist <= hist_n;
`ifdef SEQ_DET_CTRL_OVERLAP_EN
      fill <= fill_n;
`else
      fill <= hit ? '0 : fill_n;
`endif
    end
endmodule

// File: rtl/seq_det_ctrl.sv
// seq_det_ctrl: configurable serial sequence detector with run control (macro SEQ_DET_CTRL_OVERLAP_EN selects overlapping detection); ports cfg_pattern/cfg_len/cfg_target/cfg_frame, start, x_valid/x/x_ready stream, busy, match, match_cnt, done, status
import seq_det_pkg::*;
module seq_det_ctrl #(
  parameter int PAT_W   = 8,
  parameter int CNT_W   = 8,
  parameter int FRAME_W = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [PAT_W-1:0]             cfg_pattern,
  input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
  input  logic [CNT_W-1:0]             cfg_target,
  input  logic [FRAME_W-1:0]           cfg_frame,
  input  logic                         start,
  input  logic                         x_valid,
  input  logic                         x,
  output logic                         x_ready,
  output logic                         busy,
  output logic                         match,
  output logic [CNT_W-1:0]             match_cnt,
  output logic                         done,
  output logic [1:0]                   status
);
  localparam int LEN_W = $clog2(PAT_W + 1);
  state_t state, state_n;
  logic [PAT_W-1:0] pat_r;
  logic [LEN_W-1:0] len_r;
  logic [CNT_W-1:0] tgt_r, cnt_n;
  logic [FRAME_W-1:0] frm_r, bit_cnt;
  logic hit, acc, cfg_bad, tgt_end, frm_end;
  assign x_ready = state == RUN;
  assign busy    = state != IDLE;
  assign done    = state == DONE;
  always_comb begin
    cfg_bad = cfg_len == '0 || cfg_len > LEN_W'(PAT_W) || cfg_target == '0;
    acc     = state == RUN && x_valid;
    cnt_n   = match_cnt + CNT_W'(acc && hit && match_cnt != '1);
    tgt_end = acc && hit && cnt_n == tgt_r;
    frm_end = acc && frm_r != '0 && bit_cnt + FRAME_W'(1) == frm_r;
    state_n = state == IDLE ? (start ? (cfg_bad ? DONE : ARM) : IDLE) :
              state == ARM  ? RUN :
              state == RUN  ? (tgt_end || frm_end ? DONE : RUN) : IDLE;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state     <= IDLE;
      pat_r     <= '0;
      len_r     <= '0;
      tgt_r     <= '0;
      frm_r     <= '0;
      bit_cnt   <= '0;
      match     <= 1'b0;
      match_cnt <= '0;
      status    <= ST_NONE;
    end else begin
      state <= state_n;
      match <= acc && hit;
      if (state == IDLE && start) begin
        pat_r     <= cfg_pattern;
        len_r     <= cfg_len;
        tgt_r     <= cfg_target;
        frm_r     <= cfg_frame;
        match_cnt <= '0;
        status    <= cfg_bad ? ST_CFGERR : ST_NONE;
      end
      if (state == ARM) bit_cnt <= '0;
      if (acc) begin
        bit_cnt   <= bit_cnt + FRAME_W'(1);
        match_cnt <= cnt_n;
        status    <= tgt_end ? ST_TARGET : frm_end ? ST_FRAME : status;
      end
    end
  seq_match_core #(.PAT_W(PAT_W), .LEN_W(LEN_W)) u_core (
    .clk(clk), .rst(rst), .clear(state == ARM), .shift(acc), .b(x),
    .len(len_r), .pattern(pat_r), .hit(hit)
  );
endmodule

// File: tb/tb_seq_det_ctrl.sv
// tb_seq_det_ctrl: scoreboard bench for seq_det_ctrl with a bit-list reference model
module tb_seq_det_ctrl;
`ifdef SEQ_DET_CTRL_OVERLAP_EN
  localparam bit OV = 1'b1;
`else
  localparam bit OV = 1'b0;
`endif
  logic clk = 1'b0, rst = 1'b1;
  logic [7:0] cfg_pattern = '0;
  logic [3:0] cfg_len = '0;
  logic [7:0] cfg_target = '0;
  logic [15:0] cfg_frame = '0;
  logic start = 1'b0, x_valid = 1'b0, x = 1'b0;
  logic x_ready, busy, match, done;
  logic [7:0] match_cnt;
  logic [1:0] status;
  always #5 clk = ~clk;
  seq_det_ctrl dut (
    .clk(clk), .rst(rst), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
    .cfg_target(cfg_target), .cfg_frame(cfg_frame), .start(start),
    .x_valid(x_valid), .x(x), .x_ready(x_ready), .busy(busy), .match(match),
    .match_cnt(match_cnt), .done(done), .status(status)
  );
  typedef struct {bit is_done; int cnt; int st;} ev_t;
  ev_t q[$];
  int checks = 0, errors = 0;
  logic [7:0] m_pat;
  int m_len, m_tgt, m_frm, m_since, m_cnt, m_st;
  bit m_done;
  int m_bits[$];
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", n, act, exp);
    end
  endtask
  always @(negedge clk) if (!rst) begin
    ev_t ev;
    if (match) begin
      if (q.size() == 0) chk("unexpected_match", 1, 0);
      else begin
        ev = q.pop_front();
        chk("match_kind", ev.is_done, 0);
        chk("match_cnt_at_match", match_cnt, ev.cnt);
      end
    end
    if (done) begin
      if (q.size() == 0) chk("unexpected_done", 1, 0);
      else begin
        ev = q.pop_front();
        chk("done_kind", ev.is_done, 1);
        chk("done_match_cnt", match_cnt, ev.cnt);
        chk("done_status", status, ev.st);
        chk("done_x_ready", x_ready, 0);
      end
    end
  end
  // Reference: a match is the last len accepted bits equal to the pattern (newest bit vs pattern bit 0),
  // counting only bits since the previous match when detection is non-overlapping.
  task automatic model_bit(input int b);
    bit hit;
    m_bits.push_back(b);
    m_since++;
    hit = m_since >= m_len;
    for (int i = 0; i < m_len && hit; i++) if (m_bits[$-i] != int'(m_pat[i])) hit = 0;
    if (hit) begin
      if (m_cnt < 255) m_cnt++;
      q.push_back('{0, m_cnt, 0});
      if (!OV) m_since = 0;
    end
    if (hit && m_cnt == m_tgt) begin m_done = 1; m_st = 1; end
    else if (m_frm != 0 && m_bits.size() == m_frm) begin m_done = 1; m_st = 2; end
    if (m_done) q.push_back('{1, m_cnt, m_st});
  endtask
  task automatic run(input logic [7:0] pat, input int len, input int tgt, input int frm,
                     input logic [63:0] strm, input bit rnd, input bit gaps, input bit poke,
                     input bit abort, input int nmax);
    bit bad, acc;
    int n, b;
    @(negedge clk);
    cfg_pattern = pat; cfg_len = 4'(len); cfg_target = 8'(tgt); cfg_frame = 16'(frm); start = 1;
    bad = len == 0 || len > 8 || tgt == 0;
    m_pat = pat; m_len = len; m_tgt = tgt; m_frm = frm;
    m_since = 0; m_cnt = 0; m_st = 0; m_done = 0; m_bits.delete();
    if (bad) q.push_back('{1, 0, 3});
    @(negedge clk);
    start = 0;
    cfg_pattern = 8'($urandom); cfg_len = 4'($urandom); cfg_target = 8'($urandom); cfg_frame = 16'($urandom);
    chk("busy_t1", busy, 1);
    chk("x_ready_t1", x_ready, 0);
    if (bad) begin
      @(negedge clk);
      chk("busy_after_cfgerr", busy, 0);
      chk("x_ready_after_cfgerr", x_ready, 0);
      chk("cfgerr_queue_drained", q.size(), 0);
      chk("cfgerr_status_hold", status, 3);
      return;
    end
    @(negedge clk);
    chk("x_ready_t2", x_ready, 1);
    n = 0;
    while (!m_done && n < nmax) begin
      b = rnd ? int'($urandom % 2) : int'(strm[n]);
      repeat (gaps ? $urandom % 4 : 0) begin
        @(negedge clk);
        x_valid = 0; x = 1'($urandom); start = 0;
      end
      acc = 0;
      for (int k = 0; k < 8 && !acc; k++) begin
        @(negedge clk);
        x_valid = 1; x = 1'(b);
        start = poke && n == 2;
        if (start) cfg_len = 0;
        if (x_ready) acc = 1;
      end
      if (!acc) begin chk("accept_timeout", 0, 1); break; end
      model_bit(b);
      n++;
    end
    @(negedge clk);
    x_valid = 0; start = 0;
    if (!m_done) begin
      if (!abort) chk("run_ended", 0, 1);
      @(posedge clk);
      #1 rst = 1;
      @(negedge clk);
      chk("rst_busy", busy, 0);
      chk("rst_x_ready", x_ready, 0);
      chk("rst_match", match, 0);
      chk("rst_done", done, 0);
      chk("rst_match_cnt", match_cnt, 0);
      chk("rst_status", status, 0);
      q.delete();
      rst = 0;
      repeat (4) @(negedge clk);
      chk("rst_stays_idle", busy, 0);
      return;
    end
    for (int k = 0; k < 6 && q.size() != 0; k++) @(posedge clk);
    chk("queue_drained", q.size(), 0);
    @(negedge clk);
    chk("idle_after_done", busy, 0);
    chk("hold_match_cnt", match_cnt, m_cnt);
    chk("hold_status", status, m_st);
  endtask
  initial begin
    int len, frm;
    repeat (3) @(negedge clk);
    chk("reset_busy", busy, 0);
    chk("reset_x_ready", x_ready, 0);
    chk("reset_match", match, 0);
    chk("reset_done", done, 0);
    chk("reset_match_cnt", match_cnt, 0);
    chk("reset_status", status, 0);
    rst = 0;
    run(8'b1011, 4, 5, 7, 64'b1101101, 0, 0, 0, 0, 100);
    chk("d_1011_cnt", match_cnt, OV ? 2 : 1);
    chk("d_1011_status", status, 2);
    run(8'b1011, 4, OV ? 2 : 1, 0, 64'b1101101, 0, 0, 0, 0, 100);
    chk("d_target_cnt", match_cnt, OV ? 2 : 1);
    chk("d_target_status", status, 1);
    run(8'b1011, 4, 5, 5, 64'b0, 0, 0, 0, 0, 100);
    chk("d_frame_cnt", match_cnt, 0);
    chk("d_frame_status", status, 2);
    run(8'b1011, 0, 5, 7, 64'b0, 0, 0, 0, 0, 100);
    run(8'b1011, 4, 0, 7, 64'b0, 0, 0, 0, 0, 100);
    run(8'b1011, 9, 3, 7, 64'b0, 0, 0, 0, 0, 100);
    run(8'b1011, 4, 5, 7, 64'b1101101, 0, 1, 0, 0, 100);
    chk("d_gaps_cnt", match_cnt, OV ? 2 : 1);
    run(8'b1011, 4, 5, 7, 64'b1101101, 0, 1, 1, 0, 100);
    chk("d_poke_cnt", match_cnt, OV ? 2 : 1);
    run(8'b0, 1, 5, 0, 64'b0, 0, 0, 0, 1, 3);
    run(8'b1, 1, 255, 0, 64'b0, 0, 0, 0, 1, 300);
    for (int r = 0; r < 40; r++) begin
      len = $urandom_range(1, 8);
      frm = ($urandom % 3 == 0) ? 0 : $urandom_range(len, 40);
      if (frm == 0) len = $urandom_range(1, 3);
      if (r % 10 == 9) run(8'($urandom), 0, 3, frm, 64'b0, 1, 1, 0, 0, 1000);
      else run(8'($urandom), len, $urandom_range(1, 4), frm, 64'b0, 1, r % 2 == 1, r % 7 == 3, 0, 1000);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
